// File: rtl/can_frame_rx.sv
// Simplified CAN standard-frame receiver: one bus bit per can_clk, no stuffing.
// Frame visible one cycle after the last EOF bit; a full holding register drops new frames (rx_overrun).
module can_frame_rx #(
   parameter int CHECK_CRC      = 0,
   parameter int IDLE_RECESSIVE = 7
) (
   input  logic        can_clk,
   input  logic        reset,
   input  logic        can_hi_in,
   input  logic        can_lo_in,
   input  logic        rx_ready,
   output logic        rx_valid,
   output logic [10:0] rx_id,
   output logic [3:0]  rx_dlc,
   output logic [63:0] rx_data,
   output logic [14:0] rx_crc,
   output logic        rx_error,
   output logic [1:0]  rx_err_code,
   output logic        rx_overrun,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ID, S_CTRL, S_DLC, S_DATA, S_CRC, S_TAIL, S_EOF, S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic [6:0]  cnt, cnt_nxt;
   logic [10:0] id_sr;
   logic [3:0]  dlc_sr;
   logic [63:0] data_sr;
   logic [14:0] crc_sr;
   logic [14:0] crc_calc;

   logic        rx_bit;
   logic        bad_bit;
   logic [3:0]  nbytes;
   logic [6:0]  data_bits;
   logic [3:0]  dlc_full;
   logic [14:0] crc_full;
   logic [14:0] crc_step;
   logic        err;
   logic [1:0]  err_code_nxt;
   logic        frame_done;

   assign rx_bit    = can_lo_in;
   assign bad_bit   = (can_hi_in == can_lo_in);
   assign nbytes    = dlc_sr[3] ? 4'd8 : dlc_sr;
   assign data_bits = {nbytes, 3'b000};
   assign dlc_full  = {dlc_sr[2:0], rx_bit};
   assign crc_full  = {crc_sr[13:0], rx_bit};
   assign crc_step  = {crc_calc[13:0], 1'b0} ^ ((rx_bit ^ crc_calc[14]) ? 15'h4599 : 15'h0000);
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt + 7'd1;
      err          = 1'b0;
      err_code_nxt = 2'd0;
      frame_done   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = 7'd0;
            if (!bad_bit && !rx_bit) state_nxt = S_ID;
         end
         S_ID: if (cnt == 7'd10) state_nxt = S_CTRL;
         S_CTRL: begin
            if (rx_bit) begin
               err          = 1'b1;
               err_code_nxt = 2'd2;
            end else if (cnt == 7'd1) begin
               state_nxt = S_DLC;
            end
         end
         S_DLC: if (cnt == 7'd3) state_nxt = (dlc_full == 4'd0) ? S_CRC : S_DATA;
         S_DATA: if (cnt == data_bits - 7'd1) state_nxt = S_CRC;
         S_CRC: begin
            if (cnt == 7'd14) begin
               if (CHECK_CRC != 0 && crc_full != crc_calc) begin
                  err          = 1'b1;
                  err_code_nxt = 2'd3;
               end else begin
                  state_nxt = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            // delimiter, ACK slot, delimiter: 1,0,1
            if (rx_bit != (cnt != 7'd1)) begin
               err          = 1'b1;
               err_code_nxt = 2'd2;
            end else if (cnt == 7'd2) begin
               state_nxt = S_EOF;
            end
         end
         S_EOF: begin
            if (!rx_bit) begin
               err          = 1'b1;
               err_code_nxt = 2'd2;
            end else if (cnt == 7'd6) begin
               state_nxt  = S_IDLE;
               frame_done = 1'b1;
            end
         end
         S_ERR: begin
            if (bad_bit || !rx_bit)                       cnt_nxt   = 7'd0;
            else if (cnt == 7'(IDLE_RECESSIVE - 1))       state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (state != S_IDLE && state != S_ERR && bad_bit) begin
         err          = 1'b1;
         err_code_nxt = 2'd1;
      end
      if (err) begin
         state_nxt  = S_ERR;
         frame_done = 1'b0;
      end
      if (state_nxt != state) cnt_nxt = 7'd0;
   end

   always_ff @(posedge can_clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= 7'd0;
         id_sr       <= 11'd0;
         dlc_sr      <= 4'd0;
         data_sr     <= 64'd0;
         crc_sr      <= 15'd0;
         crc_calc    <= 15'd0;
         rx_valid    <= 1'b0;
         rx_id       <= 11'd0;
         rx_dlc      <= 4'd0;
         rx_data     <= 64'd0;
         rx_crc      <= 15'd0;
         rx_error    <= 1'b0;
         rx_err_code <= 2'd0;
         rx_overrun  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         rx_error   <= err;
         rx_overrun <= 1'b0;
         if (err) rx_err_code <= err_code_nxt;

         case (state)
            S_IDLE: begin
               if (state_nxt == S_ID) begin
                  id_sr    <= 11'd0;
                  dlc_sr   <= 4'd0;
                  data_sr  <= 64'd0;
                  crc_sr   <= 15'd0;
                  crc_calc <= 15'd0;
               end
            end
            S_ID: begin
               id_sr    <= {id_sr[9:0], rx_bit};
               crc_calc <= crc_step;
            end
            S_CTRL: crc_calc <= crc_step;
            S_DLC: begin
               dlc_sr   <= dlc_full;
               crc_calc <= crc_step;
            end
            S_DATA: begin
               // byte cnt/8 lands at rx_data[8*i+:8], first bit in its MSB
               data_sr[{cnt[5:3], ~cnt[2:0]}] <= rx_bit;
               crc_calc <= crc_step;
            end
            S_CRC: crc_sr <= crc_full;
            default: ;
         endcase

         if (frame_done && (!rx_valid || rx_ready)) begin
            rx_valid <= 1'b1;
            rx_id    <= id_sr;
            rx_dlc   <= dlc_sr;
            rx_data  <= data_sr;
            rx_crc   <= crc_sr;
         end else begin
            if (frame_done)            rx_overrun <= 1'b1;
            if (rx_valid && rx_ready)  rx_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_can_frame_rx.sv
// Bench for can_frame_rx: two instances (CRC check off/on) on one shared bus, checked
// every cycle against a stream-level frame model plus directed spot checks.
module tb_can_frame_rx;

   logic can_clk, reset, can_hi_in, can_lo_in, rx_ready;

   logic        rxv   [2];
   logic [10:0] rid   [2];
   logic [3:0]  rdlc  [2];
   logic [63:0] rdata [2];
   logic [14:0] rcrc  [2];
   logic        rerr  [2];
   logic [1:0]  rcode [2];
   logic        rovr  [2];
   logic        rbusy [2];

   can_frame_rx #(.CHECK_CRC(0), .IDLE_RECESSIVE(7)) u_dut0 (
      .can_clk(can_clk), .reset(reset), .can_hi_in(can_hi_in), .can_lo_in(can_lo_in),
      .rx_ready(rx_ready), .rx_valid(rxv[0]), .rx_id(rid[0]), .rx_dlc(rdlc[0]),
      .rx_data(rdata[0]), .rx_crc(rcrc[0]), .rx_error(rerr[0]), .rx_err_code(rcode[0]),
      .rx_overrun(rovr[0]), .busy(rbusy[0]));

   can_frame_rx #(.CHECK_CRC(1), .IDLE_RECESSIVE(7)) u_dut1 (
      .can_clk(can_clk), .reset(reset), .can_hi_in(can_hi_in), .can_lo_in(can_lo_in),
      .rx_ready(rx_ready), .rx_valid(rxv[1]), .rx_id(rid[1]), .rx_dlc(rdlc[1]),
      .rx_data(rdata[1]), .rx_crc(rcrc[1]), .rx_error(rerr[1]), .rx_err_code(rcode[1]),
      .rx_overrun(rovr[1]), .busy(rbusy[1]));

   initial can_clk = 1'b0;
   always #5 can_clk = ~can_clk;

   int errors = 0;
   int checks = 0;

   // ---------------- reference model (per instance) ----------------
   int          m_mode [2];   // 0 idle, 1 in frame, 2 error recovery
   int          m_rc   [2];
   int          m_pos  [2];
   logic [0:127] m_bits [2];
   logic        e_valid [2];
   logic [10:0] e_id    [2];
   logic [3:0]  e_dlc   [2];
   logic [63:0] e_data  [2];
   logic [14:0] e_crc   [2];
   logic        e_err   [2];
   logic [1:0]  e_code  [2];
   logic        e_ovr   [2];
   logic        e_busy  [2];

   logic [99:0] obs  [2];
   logic [99:0] expv [2];

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         obs[d]  = {rxv[d], rid[d], rdlc[d], rdata[d], rcrc[d], rerr[d], rcode[d], rovr[d], rbusy[d]};
         expv[d] = {e_valid[d], e_id[d], e_dlc[d], e_data[d], e_crc[d], e_err[d], e_code[d], e_ovr[d], e_busy[d]};
      end
   end

   function automatic logic [14:0] crc15(input logic [0:127] v, input int n);
      logic [14:0] c;
      logic        nx;
      c = 15'd0;
      for (int i = 0; i < n; i++) begin
         nx = v[i] ^ c[14];
         c  = {c[13:0], 1'b0};
         if (nx) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   task automatic model_edge();
      logic inv, b, err, done;
      logic [1:0] code;
      logic [3:0] dl;
      int p, nb, de, ce, len;
      for (int d = 0; d < 2; d++) begin
         inv = (can_hi_in == can_lo_in);
         b = can_lo_in; err = 1'b0; done = 1'b0; code = 2'd0; dl = 4'd0; nb = 0; de = 0;
         if (!reset) begin
            m_mode[d] = 0; m_rc[d] = 0; m_pos[d] = 0;
            e_valid[d] = 1'b0; e_id[d] = '0; e_dlc[d] = '0; e_data[d] = '0; e_crc[d] = '0;
            e_err[d] = 1'b0; e_code[d] = 2'd0; e_ovr[d] = 1'b0; e_busy[d] = 1'b0;
         end else begin
            case (m_mode[d])
               0: if (!inv && !b) begin m_mode[d] = 1; m_bits[d] = '0; m_pos[d] = 1; end
               1: begin
                  p = m_pos[d];
                  if (inv) begin err = 1'b1; code = 2'd1; end
                  else begin
                     m_bits[d][p] = b;
                     m_pos[d] = p + 1;
                     if ((p == 12 || p == 13) && b) begin err = 1'b1; code = 2'd2; end
                     if (p >= 18) begin
                        dl  = m_bits[d][14 +: 4];
                        nb  = (dl > 4'd8) ? 8 : int'(dl);
                        de  = 18 + 8 * nb;
                        ce  = de + 15;
                        len = de + 25;
                        if (d == 1 && p == ce - 1 && crc15(m_bits[d], de) != m_bits[d][de +: 15]) begin
                           err = 1'b1; code = 2'd3;
                        end
                        if (p >= ce && p < ce + 3 && b != (p != ce + 1)) begin err = 1'b1; code = 2'd2; end
                        if (p >= ce + 3 && !b) begin err = 1'b1; code = 2'd2; end
                        if (p == len - 1 && !err) begin done = 1'b1; m_mode[d] = 0; end
                     end
                  end
                  if (err) begin m_mode[d] = 2; m_rc[d] = 0; end
               end
               default: begin
                  if (!inv && b) begin
                     m_rc[d]++;
                     if (m_rc[d] == 7) m_mode[d] = 0;
                  end else m_rc[d] = 0;
               end
            endcase
            e_err[d] = err;
            if (err) e_code[d] = code;
            e_ovr[d] = 1'b0;
            if (done && (!e_valid[d] || rx_ready)) begin
               e_valid[d] = 1'b1;
               e_id[d]    = m_bits[d][1 +: 11];
               e_dlc[d]   = dl;
               e_crc[d]   = m_bits[d][de +: 15];
               e_data[d]  = '0;
               for (int k = 0; k < nb; k++) e_data[d][8*k +: 8] = m_bits[d][18 + 8*k +: 8];
            end else begin
               if (done) e_ovr[d] = 1'b1;
               if (e_valid[d] && rx_ready) e_valid[d] = 1'b0;
            end
            e_busy[d] = (m_mode[d] != 0);
         end
      end
   endtask

   // ---------------- stimulus plumbing ----------------
   logic [0:127] fb;
   int   flen, fde;
   logic sq_b [$];
   logic sq_i [$];

   task automatic step(input logic hi, input logic lo);
      @(negedge can_clk);
      can_hi_in = hi;
      can_lo_in = lo;
      @(posedge can_clk);
      model_edge();
      #1;
   endtask

   task automatic bitstep(input logic b, input logic inv);
      step(inv ? b : ~b, b);
   endtask

   task automatic build(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
      int nb;
      nb = (dlc > 4'd8) ? 8 : int'(dlc);
      fb = '0;
      fb[1 +: 11] = id;
      fb[14 +: 4] = dlc;
      for (int k = 0; k < nb; k++) fb[18 + 8*k +: 8] = data[8*k +: 8];
      fde = 18 + 8 * nb;
      fb[fde +: 15]      = crc15(fb, fde);
      fb[fde + 15 +: 3]  = 3'b101;
      fb[fde + 18 +: 7]  = 7'h7f;
      flen = fde + 25;
   endtask

   task automatic app_frame(input int n, input int inv_at);
      for (int i = 0; i < n; i++) begin
         sq_b.push_back(fb[i]);
         sq_i.push_back(i == inv_at);
      end
   endtask

   task automatic app_idle(input int n);
      for (int i = 0; i < n; i++) begin sq_b.push_back(1'b1); sq_i.push_back(1'b0); end
   endtask

   task automatic clear_seq();
      sq_b.delete();
      sq_i.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; rx_ready = 1'b0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs[d] !== 100'd0) begin
            errors++; $display("FAIL reset dut%0d obs=%h exp=0", d, obs[d]);
         end
      end
      reset = 1'b1;
      step(1'b0, 1'b1);
   endtask

   task automatic test_basic();
      int lat;
      lat = -1;
      clear_seq();
      build(11'h123, 4'd1, 64'h89);
      fb[fde +: 15] = 15'd0;
      app_frame(flen, -1);
      app_idle(3);
      rx_ready = 1'b1;
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL basic step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (lat < 0 && rxv[0]) lat = i;
         if (i == 50) begin
            checks++;
            if (rid[0] !== 11'h123 || rdlc[0] !== 4'd1 || rdata[0] !== 64'h89 || rcrc[0] !== 15'd0) begin
               errors++; $display("FAIL basic_fields id=%h dlc=%0d data=%h crc=%h exp 123/1/89/0",
                                   rid[0], rdlc[0], rdata[0], rcrc[0]);
            end
         end
         if (i == 51) begin
            checks++;
            if (rxv[0] !== 1'b0) begin errors++; $display("FAIL basic_consume rx_valid=%b exp=0", rxv[0]); end
         end
      end
      checks++;
      if (lat + 1 !== 51) begin errors++; $display("FAIL basic_latency cycle=%0d exp=51", lat + 1); end
   endtask

   task automatic test_overrun();
      int n_ab, novr;
      novr = 0;
      clear_seq();
      build(11'h123, 4'd1, 64'h89);
      app_frame(flen, -1);
      build(11'h456, 4'd1, 64'h12);
      app_frame(flen, -1);
      n_ab = sq_b.size();
      app_idle(3);
      for (int i = 0; i < sq_b.size(); i++) begin
         rx_ready = (i == n_ab + 1);
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL overrun step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (rovr[0]) novr++;
         if (i == n_ab) begin
            checks++;
            if (rxv[0] !== 1'b1 || rid[0] !== 11'h123 || novr !== 1) begin
               errors++; $display("FAIL overrun_hold valid=%b id=%h pulses=%0d exp 1/123/1", rxv[0], rid[0], novr);
            end
         end
         if (i == n_ab + 1) begin
            checks++;
            if (rxv[0] !== 1'b0) begin errors++; $display("FAIL overrun_consume rx_valid=%b exp=0", rxv[0]); end
         end
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_diff_error();
      int dom;
      clear_seq();
      build(11'h555, 4'd2, 64'hbeef);
      app_frame(7, 6);
      app_idle(3);
      dom = sq_b.size();
      sq_b.push_back(1'b0); sq_i.push_back(1'b0);
      app_idle(7);
      build(11'h2aa, 4'd2, 64'h3412);
      app_frame(flen, -1);
      app_idle(2);
      rx_ready = 1'b0;
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL differr step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (i == 6) begin
            checks++;
            if (rerr[0] !== 1'b1 || rcode[0] !== 2'd1) begin
               errors++; $display("FAIL differr_pulse err=%b code=%0d exp 1/1", rerr[0], rcode[0]);
            end
         end
         if (i == dom) begin
            checks++;
            if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL differr_sof_ignored busy=%b exp=1", rbusy[0]); end
         end
      end
      checks++;
      if (rxv[0] !== 1'b1 || rid[0] !== 11'h2aa || rdata[0] !== 64'h3412) begin
         errors++; $display("FAIL differr_recover valid=%b id=%h data=%h exp 1/2aa/3412", rxv[0], rid[0], rdata[0]);
      end
      rx_ready = 1'b1;
      step(1'b0, 1'b1);
      rx_ready = 1'b0;
   endtask

   task automatic test_form_error();
      int ack_at, eof_at;
      clear_seq();
      build(11'h0f0, 4'd1, 64'h5a);
      fb[fde + 16] = 1'b1;
      ack_at = fde + 16;
      app_frame(flen, -1);
      app_idle(8);
      eof_at = sq_b.size() + fde + 21;
      build(11'h0f1, 4'd0, 64'h0);
      fb[fde + 21] = 1'b0;
      eof_at = eof_at - 8 + (fde - 18) + 8 - (fde - 18);
      eof_at = sq_b.size() + fde + 21;
      app_frame(flen, -1);
      app_idle(8);
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL formerr step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (i == ack_at || i == eof_at) begin
            checks++;
            if (rerr[0] !== 1'b1 || rcode[0] !== 2'd2) begin
               errors++; $display("FAIL formerr_pulse step%0d err=%b code=%0d exp 1/2", i, rerr[0], rcode[0]);
            end
         end
      end
      checks++;
      if (rxv[0] !== 1'b0) begin errors++; $display("FAIL formerr_novalid rx_valid=%b exp=0", rxv[0]); end
   endtask

   task automatic test_dlc12();
      int lat;
      lat = -1;
      clear_seq();
      build(11'h7ff, 4'd12, 64'h0807060504030201);
      app_frame(flen, -1);
      app_idle(2);
      rx_ready = 1'b0;
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL dlc12 step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (lat < 0 && rxv[0]) lat = i;
      end
      checks++;
      if (lat + 1 !== 107) begin errors++; $display("FAIL dlc12_length cycle=%0d exp=107", lat + 1); end
      checks++;
      if (rdlc[0] !== 4'd12 || rdata[0][7:0] !== 8'h01 || rdata[0][63:56] !== 8'h08 ||
          rdata[0] !== 64'h0807060504030201) begin
         errors++; $display("FAIL dlc12_fields dlc=%0d data=%h exp 12/0807060504030201", rdlc[0], rdata[0]);
      end
      rx_ready = 1'b1;
      step(1'b0, 1'b1);
      rx_ready = 1'b0;
   endtask

   task automatic test_crc();
      int last_crc;
      clear_seq();
      build(11'h3c5, 4'd3, 64'h00c0ffee);
      app_frame(flen, -1);
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL crc_good step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
      end
      checks++;
      if (rxv[1] !== 1'b1 || rid[1] !== 11'h3c5 || rdata[1] !== 64'h00c0ffee) begin
         errors++; $display("FAIL crc_accept valid=%b id=%h data=%h exp 1/3c5/c0ffee", rxv[1], rid[1], rdata[1]);
      end
      rx_ready = 1'b1;
      step(1'b0, 1'b1);
      rx_ready = 1'b0;

      clear_seq();
      fb[fde + 7] = ~fb[fde + 7];
      last_crc = fde + 14;
      app_frame(flen, -1);
      app_idle(8);
      for (int i = 0; i < sq_b.size(); i++) begin
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL crc_bad step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
         if (i == last_crc) begin
            checks++;
            if (rerr[1] !== 1'b1 || rcode[1] !== 2'd3 || rerr[0] !== 1'b0) begin
               errors++; $display("FAIL crc_reject err1=%b code1=%0d err0=%b exp 1/3/0", rerr[1], rcode[1], rerr[0]);
            end
         end
      end
      checks++;
      if (rxv[0] !== 1'b1 || rxv[1] !== 1'b0) begin
         errors++; $display("FAIL crc_outcome valid0=%b valid1=%b exp 1/0", rxv[0], rxv[1]);
      end
      rx_ready = 1'b1;
      step(1'b0, 1'b1);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      clear_seq();
      build(11'h1a5, 4'd2, 64'h7e81);
      app_frame(23, -1);
      app_idle(10);
      for (int i = 0; i < sq_b.size(); i++) begin
         if (i == 22) reset = 1'b0;
         bitstep(sq_b[i], sq_i[i]);
         if (i == 22) begin
            for (int d = 0; d < 2; d++) begin
               checks++;
               if (rbusy[d] !== 1'b0 || rxv[d] !== 1'b0 || rerr[d] !== 1'b0 || rcode[d] !== 2'd0) begin
                  errors++; $display("FAIL midreset dut%0d busy=%b valid=%b err=%b code=%0d exp all 0",
                                      d, rbusy[d], rxv[d], rerr[d], rcode[d]);
               end
            end
            reset = 1'b1;
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL midreset step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      int r, pos;
      clear_seq();
      for (int f = 0; f < 25; f++) begin
         build(11'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom});
         r = $urandom_range(0, 3);
         pos = $urandom_range(12, flen - 1);
         if (r == 0) fb[pos] = ~fb[pos];
         app_frame(flen, (r == 1) ? pos : -1);
         app_idle($urandom_range(0, 3));
      end
      app_idle(20);
      for (int i = 0; i < sq_b.size(); i++) begin
         rx_ready = 1'($urandom_range(0, 1));
         bitstep(sq_b[i], sq_i[i]);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv[d]) begin
               errors++; $display("FAIL random step%0d dut%0d obs=%h exp=%h", i, d, obs[d], expv[d]);
            end
         end
      end
      rx_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rx_ready = 1'b0; can_hi_in = 1'b0; can_lo_in = 1'b1;
      test_reset();
      test_basic();
      test_overrun();
      test_diff_error();
      test_form_error();
      test_dlc12();
      test_crc();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
